// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: instruction fetch stage of the single-issue MIPS core.
// Holds the PC, fetches words over a req/ack handshake and presents them to the decoder.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   imem_req/imem_addr  - memory request and word address (bits [1:0] always 0)
//   imem_ack/imem_rdata - memory response, data valid in the ack cycle
//   stall               - downstream cannot consume the presented instruction
//   jump_en/jump_addr   - single-cycle redirect from the decoder's Muxif
//   instr/instr_pc      - presented instruction (zero when not valid) and its address
//   opcode/funct        - instr[31:26] / instr[5:0]
//   instr_valid         - instr holds a real fetched instruction
//   align_err           - one-cycle pulse on a jump to a misaligned target
//   fetch_err           - sticky memory timeout flag
module mips_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        jump_en,
    input  logic [31:0] jump_addr,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic        instr_valid,
    output logic        align_err,
    output logic        fetch_err
);
    typedef enum logic [1:0] {BOOT, FETCH, WAIT} state_t;
    localparam logic [7:0] TO = 8'(TIMEOUT);
    state_t      state;
    logic [31:0] pc;
    logic [7:0]  cnt;
    // Request is a pure decode of the state register, so no input reaches it combinationally.
    assign imem_req  = state == FETCH;
    assign imem_addr = pc;
    assign opcode    = instr[31:26];
    assign funct     = instr[5:0];
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            instr_pc    <= RESET_PC;
            instr       <= 32'h0;
            instr_valid <= 1'b0;
            align_err   <= 1'b0;
            fetch_err   <= 1'b0;
            cnt         <= 8'h0;
        end else begin
            align_err <= 1'b0;
            if (jump_en && state != BOOT) begin
                pc          <= {jump_addr[31:2], 2'b00};
                instr       <= 32'h0;
                instr_valid <= 1'b0;
                state       <= FETCH;
                cnt         <= 8'h0;
                align_err   <= |jump_addr[1:0];
            end else if (state == BOOT) begin
                state <= FETCH;
            end else if (state == WAIT) begin
                // The held word is consumed in the release cycle; drop it so it is not presented twice.
                if (!stall) begin
                    state       <= FETCH;
                    instr       <= 32'h0;
                    instr_valid <= 1'b0;
                end
            end else if (instr_valid && stall) begin
                // Any ack here is discarded; pc stays put so the same word is refetched.
                state <= WAIT;
                cnt   <= 8'h0;
            end else if (imem_ack) begin
                instr       <= imem_rdata;
                instr_pc    <= pc;
                pc          <= pc + 32'd4;
                instr_valid <= 1'b1;
                cnt         <= 8'h0;
            end else begin
                instr       <= 32'h0;
                instr_valid <= 1'b0;
                if (cnt != TO) cnt <= cnt + 8'd1;
                if (cnt >= TO - 8'd1) fetch_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb_mips_fetch_unit: randomized scoreboard bench for mips_fetch_unit against a stream-level model.
module tb_mips_fetch_unit;
    localparam logic [31:0] RPC = 32'h0000_0040;
    localparam int          TMO = 4;
    logic        clk = 1'b0;
    logic        reset, imem_req, imem_ack, stall, jump_en, instr_valid, align_err, fetch_err;
    logic [31:0] imem_addr, imem_rdata, jump_addr, instr, instr_pc;
    logic [5:0]  opcode, funct;
    int checks = 0, errors = 0;
    logic [31:0] jq[$];
    int guard = 0, tcount = 0, accepts = 0;

    mips_fetch_unit #(.RESET_PC(RPC), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall), .jump_en(jump_en),
        .jump_addr(jump_addr), .instr(instr), .instr_pc(instr_pc), .opcode(opcode),
        .funct(funct), .instr_valid(instr_valid), .align_err(align_err), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    // ack_pct < 0 means ack on every third step; jump_pct == 100 uses the given target.
    task automatic step(input int ack_pct, input int stall_pct, input int jump_pct, input logic [31:0] jt);
        @(posedge clk); #1;
        reset = 1'b0;
        tcount++;
        stall = instr_valid && ($urandom_range(99) < stall_pct);
        imem_ack = imem_req && (ack_pct < 0 ? (tcount % 3 == 0) : ($urandom_range(99) < ack_pct));
        imem_rdata = imem_ack ? mem(imem_addr) : $urandom;
        jump_en = !stall && guard == 0 && ($urandom_range(99) < jump_pct);
        if (jump_en) begin
            case ($urandom_range(2))
                0: jump_addr = $urandom;
                1: jump_addr = {28'hFFFF_FFF, 4'($urandom)};
                default: jump_addr = {24'h0, 8'($urandom)};
            endcase
            if (jump_pct == 100) jump_addr = jt;
            jq.push_back({jump_addr[31:2], 2'b00});
        end
        if (guard > 0) guard--;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        stall = 1'b0;
        jump_en = 1'b0;
        imem_ack = $urandom_range(1) == 1;
        imem_rdata = $urandom;
        guard = 2;
    endtask

    // Monitor: checks every cycle against the expected instruction stream and flag predictions.
    initial begin
        logic        started = 1'b0, prev_reset = 1'b0, at1 = 1'b0;
        logic        exp_align = 1'b0, exp_fe = 1'b0, prev_hold = 1'b0, prev_addr_hold = 1'b0;
        logic [31:0] exp_pc = RPC, prev_instr = 0, prev_ipc = 0, prev_addr = 0;
        int          since = 0, run = 0;
        forever begin
            @(negedge clk);
            if (prev_reset) started = 1'b1;
            if (started) begin
                since = prev_reset ? 0 : since + 1;
                chk("align_err", 32'(align_err), 32'(exp_align));
                chk("fetch_err", 32'(fetch_err), 32'(exp_fe));
                chk("addr_lsb", 32'(imem_addr[1:0]), 32'h0);
                if (!instr_valid) begin
                    chk("bubble_instr", instr, 32'h0);
                    chk("bubble_opfunct", {20'h0, opcode, funct}, 32'h0);
                end
                if (prev_hold) begin
                    chk("hold_instr", instr, prev_instr);
                    chk("hold_pc", instr_pc, prev_ipc);
                    chk("hold_valid", 32'(instr_valid), 32'h1);
                    chk("wait_req", 32'(imem_req), 32'h0);
                end
                if (prev_addr_hold) chk("addr_hold", imem_addr, prev_addr);
                if (since == 0) begin
                    chk("rst_req", 32'(imem_req), 32'h0);
                    chk("rst_valid", 32'(instr_valid), 32'h0);
                    chk("rst_instr", instr, 32'h0);
                    chk("rst_instr_pc", instr_pc, RPC);
                    chk("rst_addr", imem_addr, RPC);
                end
                if (since == 1) begin
                    chk("first_req", 32'(imem_req), 32'h1);
                    chk("first_addr", imem_addr, RPC);
                end
                if (since == 2 && at1) begin
                    chk("first_valid", 32'(instr_valid), 32'h1);
                    chk("first_instr_pc", instr_pc, RPC);
                end
            end
            if (reset) begin
                exp_pc = RPC;
                exp_align = 1'b0;
                exp_fe = 1'b0;
                run = 0;
                prev_hold = 1'b0;
                prev_addr_hold = 1'b0;
            end else if (started) begin
                if (instr_valid && !stall) begin
                    chk("stream_pc", instr_pc, exp_pc);
                    chk("stream_instr", instr, mem(exp_pc));
                    chk("stream_opfunct", {20'h0, opcode, funct}, {20'h0, exp_pc[31:26] ^ 6'h29, exp_pc[5:0]});
                    exp_pc = exp_pc + 32'd4;
                    accepts++;
                end
                if (jump_en) begin
                    chk("jump_queue", 32'(jq.size() != 0), 32'h1);
                    if (jq.size() != 0) exp_pc = jq.pop_front();
                end
                exp_align = jump_en && jump_addr[1:0] != 2'b00;
                if (imem_req && !jump_en && !(instr_valid && stall) && !imem_ack) begin
                    run++;
                    if (run >= TMO) exp_fe = 1'b1;
                end else run = 0;
                prev_hold = instr_valid && stall && !jump_en;
                prev_instr = instr;
                prev_ipc = instr_pc;
                prev_addr_hold = imem_req && !imem_ack && !jump_en;
                prev_addr = imem_addr;
                if (since == 1) at1 = imem_ack && !jump_en;
            end
            prev_reset = reset;
        end
    end

    initial begin
        reset = 1'b1;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        stall = 1'b0;
        jump_en = 1'b0;
        jump_addr = 32'h0;
        repeat (2) @(posedge clk);
        do_reset();
        repeat (3) step(100, 0, 0, 0);
        repeat (3) step(100, 100, 0, 0);
        repeat (3) step(100, 0, 0, 0);
        step(100, 0, 100, 32'h0000_0102);
        repeat (6) step(100, 0, 0, 0);
        repeat (30) step(-1, 0, 0, 0);
        step(100, 0, 100, 32'hFFFF_FFF4);
        repeat (8) step(100, 0, 0, 0);
        repeat (10) step(0, 0, 0, 0);
        repeat (10) step(100, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(999) < 3) do_reset();
            else step(70, 20, 5, 0);
        end
        repeat (3) step(100, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("accept_count_min", 32'(accepts >= 100), 32'h1);
        chk("jump_queue_drained", 32'(jq.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips_fetch_unit.md
# mips_fetch_unit

Instruction fetch stage of the single-issue MIPS core, directly upstream of the control decoder. Holds the program counter, fetches 32-bit words from instruction memory over a req/ack handshake, and presents the fetched instruction, with its `opcode`/`funct` fields split out, to the decoder and datapath. Accepts jump/jr redirects from the control path's jump indication (`Muxif`) and stalls from downstream. Presents an all-zero instruction whenever no valid instruction is held, so the decoder falls to its all-controls-off state.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset.
- `TIMEOUT`, default 15: consecutive FETCH cycles without `imem_ack` before `fetch_err` sets. Range 1..255.

- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `imem_req` out 1: instruction memory request.
- `imem_addr` out 32: word address being fetched; bits [1:0] always 0.
- `imem_ack` in 1: memory response; `imem_rdata` is valid in the ack cycle.
- `imem_rdata` in 32: fetched instruction word.
- `stall` in 1: downstream cannot consume the presented instruction this cycle.
- `jump_en` in 1: single-cycle redirect request, driven from the decoder's `Muxif`.
- `jump_addr` in 32: redirect target.
- `instr` out 32: presented instruction; `32'h0` when `instr_valid`=0.
- `instr_pc` out 32: address of `instr`.
- `opcode` out 6: `instr[31:26]`, combinational from the register.
- `funct` out 6: `instr[5:0]`, combinational from the register.
- `instr_valid` out 1: `instr` holds a real fetched instruction.
- `align_err` out 1: one-cycle pulse when `jump_addr[1:0]` != 0 on an accepted jump.
- `fetch_err` out 1: sticky; cleared only by reset.

## Operation
- Internal `pc` register holds the next address to fetch. `imem_addr` = `pc`.
- The FSM has three states:
  - BOOT: entered on reset. `imem_req`=0. Unconditionally goes to FETCH after 1 cycle.
  - FETCH: `imem_req`=1.
  - WAIT: `imem_req`=0. The output register is frozen.
- Accept rule: downstream consumes the instruction in any cycle with `instr_valid`=1 and `stall`=0.
- Priority order each cycle:
  1. reset
  2. `jump_en`
  3. stall
  4. ack
- `jump_en`=1 (any state except BOOT; ignored in BOOT):
  - `pc` <= `{jump_addr[31:2],2'b00}`.
  - `instr_valid` <= 0 and `instr` <= 0.
  - Any `imem_ack` in the same cycle is discarded.
  - State <= FETCH and the timeout counter clears.
  - `align_err` pulses if `jump_addr[1:0]` != 0.
- In FETCH with `instr_valid`=1 and `stall`=1: the output register holds and state <= WAIT. An `imem_ack` in this cycle is discarded and `pc` is unchanged, so the same address is refetched later.
- In FETCH, not stalled, with `imem_ack`=1: `instr` <= `imem_rdata`, `instr_pc` <= `pc`, `pc` <= `pc+4` (mod 2^32, wraps `FFFF_FFFC`->`0000_0000`), `instr_valid` <= 1.
- In FETCH, not stalled, with `imem_ack`=0: `instr_valid` <= 0 and `instr` <= 0 (bubble).
- In WAIT: state <= FETCH when `stall`=0. The held instruction is accepted in that cycle.
- Timeout counter (8-bit):
  - Increments in FETCH cycles with no ack and not stalled.
  - Clears on ack, on jump, and on leaving FETCH.
  - Reaching `TIMEOUT` sets `fetch_err`.
  - Fetching continues at the same `pc` and the counter saturates.
- Reset values:
  - `pc`=`RESET_PC`, `instr_pc`=`RESET_PC`
  - `instr`=0, `instr_valid`=0
  - `imem_req`=0, `align_err`=0, `fetch_err`=0
  - state=BOOT, counter=0
- Reset mid-fetch drops any outstanding request. A reset-cycle ack is ignored.

## Timing
- Fetch latency: the cycle after `imem_ack` shows the word on `instr` with `instr_valid`=1.
- With zero-wait memory (ack in the request cycle) and no stall, throughput is 1 instruction/cycle. The first valid instruction appears 2 cycles after reset deasserts (BOOT, then FETCH).
- Jump: the cycle after `jump_en`, `imem_addr`=target and `instr_valid`=0. The target instruction appears 1 cycle after its ack. This gives a 1-cycle bubble with zero-wait memory; no delay slot.
- `imem_req` is a registered state decode with no combinational path from `stall`, `jump_en` or `imem_ack`.
- `opcode`/`funct` are pure slices of the `instr` register. This gives the decoder a full cycle.

## Test plan
- Reset with `RESET_PC`=`32'h0000_0040` and zero-wait memory returning `mem[a]`=`a^32'hA5A5_0000`:
  - Cycle 0 after reset: `imem_req`=0.
  - Cycle 1: `imem_addr`=`40`.
  - Cycle 2: `instr`=`A5A5_0040`, `instr_pc`=`40`, `instr_valid`=1.
  - Then one instruction per cycle at `44`, `48`.
- `stall`=1 for 3 cycles while `instr`=`A5A5_0044`: the output holds for 3 cycles and `imem_req`=0 in WAIT. After release, the next word is `A5A5_0048`; no skip and no duplicate.
- `jump_en` with `jump_addr`=`32'h0000_0102` while `imem_ack`=1 for address `50`:
  - The `50` word is never presented.
  - `align_err` pulses once.
  - The next valid `instr_pc` is `100`.
- Memory acking every third cycle: `instr_valid` toggles with bubbles carrying `instr`=0 and `opcode`=`funct`=0. The PC sequence is gap-free.
- `TIMEOUT`=4 with `imem_ack` held low: `fetch_err` rises after 4 FETCH cycles and stays 1. `imem_addr` is unchanged. After acks resume, `fetch_err` stays set until reset.
- `pc`=`FFFF_FFFC` with an ack: the presented `instr_pc` is `FFFF_FFFC` and the next `imem_addr` is `0000_0000`.
